// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the strip convolution engine.
package conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_EMIT,
    ST_DONE
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Width of a counter that must hold 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : clog2(n);
  endfunction

  // Tap index width; a 1x1 kernel still needs a one-bit index port.
  function automatic int idx_w(input int k);
    return cnt_w(k * k);
  endfunction

  // Full-precision patch sum: product width plus growth for K*K terms.
  function automatic int acc_w(input int data_w, input int k);
    return 2 * data_w + clog2(k * k);
  endfunction

  // Number of patch positions along one dimension; leftover pixels are dropped.
  function automatic int out_dim(input int full, input int k, input int stride);
    return (full - k) / stride + 1;
  endfunction

endpackage

// File: rtl/conv_mac_lane.sv
// Single registered signed multiply-accumulate lane.
module conv_mac_lane #(
  parameter int DATA_W = 9,
  parameter int ACC_W  = 22
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    acc_q;

  assign prod     = $signed(a) * $signed(b);
  assign prod_ext = ACC_W'(prod);

  // Accumulate one product per enabled cycle; clr restarts the sum with this product.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= clr ? prod_ext : acc_q + prod_ext;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/im2col_conv_strip_engine.sv
// Slides a KxK signed kernel over one feature-map strip, one tap per cycle,
// and streams each patch sum over a valid/ready port in row-major order.
module im2col_conv_strip_engine
  import conv_pkg::*;
#(
  parameter int DATA_W  = 9,
  parameter int K       = 3,
  parameter int IMG_W   = 224,
  parameter int STRIP_H = 28,
  parameter int STRIDE  = 1,
  parameter int RD_LAT  = 2,
  parameter int ADDR_W  = 16,
  localparam int IDX_W  = idx_w(K),
  localparam int ACC_W  = acc_w(DATA_W, K)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] fm_base,
  input  logic              k_we,
  input  logic [IDX_W-1:0]  k_idx,
  input  logic [DATA_W-1:0] k_data,
  output logic              fm_rd_en,
  output logic [ADDR_W-1:0] fm_addr,
  input  logic [DATA_W-1:0] fm_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int NTAP  = K * K;
  localparam int OUT_W = out_dim(IMG_W, K, STRIDE);
  localparam int OUT_H = out_dim(STRIP_H, K, STRIDE);
  localparam int KC_W  = cnt_w(K);
  localparam int COL_W = cnt_w(OUT_W);
  localparam int ROW_W = cnt_w(OUT_H);

  state_t state, state_nx;

  logic [ADDR_W-1:0]        base_q;
  logic [KC_W-1:0]          kx, ky;
  logic [COL_W-1:0]         col;
  logic [ROW_W-1:0]         row;
  logic signed [DATA_W-1:0] taps [NTAP];
  logic [RD_LAT-1:0]        vld_pipe;
  logic [IDX_W-1:0]         idx_pipe [RD_LAT];
  logic                     last_p;
  logic [ACC_W-1:0]         acc;
  logic [ACC_W-1:0]         out_data_q;
  logic [ADDR_W-1:0]        out_addr_q;
  logic                     out_last_q;

  logic              start_ok, fetch, kx_end, ky_end, col_end, row_end, hs;
  logic              vld_out;
  logic [IDX_W-1:0]  idx_cur, idx_out;
  logic [31:0]       pix_off;
  logic [DATA_W-1:0] tap_sel;

  assign start_ok = (state == ST_IDLE) && start;
  assign fetch    = (state == ST_FETCH);
  assign kx_end   = (kx == KC_W'(K - 1));
  assign ky_end   = (ky == KC_W'(K - 1));
  assign col_end  = (col == COL_W'(OUT_W - 1));
  assign row_end  = (row == ROW_W'(OUT_H - 1));
  assign hs       = (state == ST_EMIT) && out_ready;
  assign idx_cur  = IDX_W'(32'(ky) * K + 32'(kx));
  assign vld_out  = vld_pipe[RD_LAT-1];
  assign idx_out  = idx_pipe[RD_LAT-1];
  assign pix_off  = (32'(row) * STRIDE + 32'(ky)) * IMG_W + 32'(col) * STRIDE + 32'(kx);
  assign tap_sel  = taps[idx_out];

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Next-state and strobe outputs; EMIT holds until the consumer takes the result.
  always_comb begin
    state_nx  = state;
    fm_rd_en  = 1'b0;
    fm_addr   = '0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = (state != ST_IDLE);
    done      = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_FETCH;
      ST_FETCH: begin
        fm_rd_en = 1'b1;
        fm_addr  = base_q + ADDR_W'(pix_off);
        if (kx_end && ky_end) state_nx = ST_DRAIN;
      end
      ST_DRAIN: if (last_p) state_nx = ST_EMIT;
      ST_EMIT: begin
        out_valid = 1'b1;
        out_last  = out_last_q;
        if (out_ready) state_nx = (col_end && row_end) ? ST_DONE : ST_FETCH;
      end
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Tap walk inside a patch (kx fastest) and patch walk across the strip.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q <= '0;
      kx     <= '0;
      ky     <= '0;
      col    <= '0;
      row    <= '0;
    end else if (start_ok) begin
      base_q <= fm_base;
      kx     <= '0;
      ky     <= '0;
      col    <= '0;
      row    <= '0;
    end else if (fetch) begin
      kx <= kx_end ? '0 : kx + 1'b1;
      if (kx_end) ky <= ky_end ? '0 : ky + 1'b1;
    end else if (hs) begin
      col <= col_end ? '0 : col + 1'b1;
      if (col_end) row <= row + 1'b1;
    end
  end

  // Kernel taps: loadable only while idle, kept across strips.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NTAP; i++) taps[i] <= '0;
    end else if (k_we && (state == ST_IDLE) && (32'(k_idx) < NTAP)) begin
      taps[k_idx] <= k_data;
    end
  end

  // Read-valid pipe matching memory latency; last_p marks the cycle after the final tap MAC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      last_p   <= 1'b0;
    end else begin
      vld_pipe[0] <= fetch;
      for (int i = 1; i < RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
      last_p <= vld_out && (idx_out == IDX_W'(NTAP - 1));
    end
  end

  // Tap index travelling beside the read-valid pipe.
  always_ff @(posedge clk) begin
    idx_pipe[0] <= idx_cur;
    for (int i = 1; i < RD_LAT; i++) idx_pipe[i] <= idx_pipe[i-1];
  end

  conv_mac_lane #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .clr   (idx_out == '0),
    .en    (vld_out),
    .a     (tap_sel),
    .b     (fm_rdata),
    .acc   (acc)
  );

  // Capture the finished patch sum and its position when entering EMIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data_q <= '0;
      out_addr_q <= '0;
      out_last_q <= 1'b0;
    end else if ((state == ST_DRAIN) && last_p) begin
      out_data_q <= acc;
      out_addr_q <= ADDR_W'(32'(row) * OUT_W + 32'(col));
      out_last_q <= col_end && row_end;
    end
  end

  assign out_data = out_data_q;
  assign out_addr = out_addr_q;

endmodule

// File: tb/tb_im2col_conv_strip_engine.sv
// Directed bench for the strip convolver: 6x5 strip, 3x3 kernel, two-cycle reads.
module tb_im2col_conv_strip_engine;

  localparam int DATA_W = 9;
  localparam int ACC_W  = 22;
  localparam int ADDR_W = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic              start = 1'b0, start2 = 1'b0;
  logic [ADDR_W-1:0] fm_base = '0;
  logic              k_we = 1'b0;
  logic [3:0]        k_idx = '0;
  logic [DATA_W-1:0] k_data = '0;
  logic              out_ready = 1'b1, out_ready2 = 1'b1;

  logic              fm_rd_en, fm_rd_en2;
  logic [ADDR_W-1:0] fm_addr, fm_addr2;
  logic [DATA_W-1:0] fm_rdata, fm_rdata2;
  logic              out_valid, out_valid2, out_last, out_last2;
  logic signed [ACC_W-1:0] out_data, out_data2;
  logic [ADDR_W-1:0] out_addr, out_addr2;
  logic              busy, busy2, done, done2;

  im2col_conv_strip_engine #(
    .DATA_W(DATA_W), .K(3), .IMG_W(6), .STRIP_H(5), .STRIDE(1), .RD_LAT(2), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .fm_base(fm_base),
    .k_we(k_we), .k_idx(k_idx), .k_data(k_data),
    .fm_rd_en(fm_rd_en), .fm_addr(fm_addr), .fm_rdata(fm_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .out_last(out_last), .busy(busy), .done(done)
  );

  im2col_conv_strip_engine #(
    .DATA_W(DATA_W), .K(3), .IMG_W(6), .STRIP_H(5), .STRIDE(2), .RD_LAT(2), .ADDR_W(ADDR_W)
  ) dut2 (
    .clk(clk), .reset(reset), .start(start2), .fm_base(fm_base),
    .k_we(k_we), .k_idx(k_idx), .k_data(k_data),
    .fm_rd_en(fm_rd_en2), .fm_addr(fm_addr2), .fm_rdata(fm_rdata2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .out_addr(out_addr2), .out_last(out_last2), .busy(busy2), .done(done2)
  );

  // Feature-map memory with two-cycle read latency per engine.
  logic signed [DATA_W-1:0] fm_mem [0:511];
  logic [DATA_W-1:0] s1 = '0, s2 = '0, t1 = '0, t2 = '0;
  always @(posedge clk) begin
    if (fm_rd_en)  s1 <= fm_mem[fm_addr[8:0]];
    if (fm_rd_en2) t1 <= fm_mem[fm_addr2[8:0]];
    s2 <= s1;
    t2 <= t1;
  end
  assign fm_rdata  = s2;
  assign fm_rdata2 = t2;

  int done_cnt = 0, done2_cnt = 0;
  logic [ADDR_W-1:0] rd2_q[$];
  always @(negedge clk) begin
    if (done)  done_cnt  <= done_cnt + 1;
    if (done2) done2_cnt <= done2_cnt + 1;
    if (fm_rd_en2) rd2_q.push_back(fm_addr2);
  end

  int checks = 0, failures = 0;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  logic signed [ACC_W-1:0] r_data [16];
  int r_addr [16];
  bit r_last [16];

  task automatic write_tap(input int idx, input int val);
    k_we = 1'b1; k_idx = 4'(idx); k_data = DATA_W'(val);
    @(negedge clk);
    k_we = 1'b0;
  endtask

  task automatic all_taps(input int val);
    for (int i = 0; i < 9; i++) write_tap(i, val);
  endtask

  task automatic start_strip(input int base);
    fm_base = ADDR_W'(base); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Accepts n results from dut; stalls out_ready for 5 cycles on result stall_idx.
  task automatic collect(input int n, input int stall_idx, output int got);
    int cyc, stall;
    logic signed [ACC_W-1:0] held;
    got = 0; cyc = 0; stall = 0; held = '0;
    while (got < n && cyc < 3000) begin
      if (got == stall_idx && stall > 0) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, held);
        check("stall_rd_en", fm_rd_en, 0);
      end
      if (out_valid) begin
        if (got == stall_idx && stall < 5) begin
          if (stall == 0) held = out_data;
          out_ready = 1'b0;
          stall++;
        end else begin
          out_ready = 1'b1;
          if (got < 16) begin
            r_data[got] = out_data; r_addr[got] = int'(out_addr); r_last[got] = out_last;
          end
          got++;
        end
      end else begin
        out_ready = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    check("collect_count", got, n);
  endtask

  initial begin
    int got, lat, d0, cyc;
    for (int a = 0; a < 512; a++) fm_mem[a] = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_fm_rd_en", fm_rd_en, 0);
    check("rst_fm_addr", fm_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    reset = 1'b0;
    @(negedge clk);

    // All-ones kernel over all-ones map
    all_taps(1);
    for (int a = 0; a < 512; a++) fm_mem[a] = 9'sd1;
    d0 = done_cnt;
    start_strip(0);
    check("busy_after_start", busy, 1);
    lat = 0;
    while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
    check("first_latency", lat, 12);
    collect(12, -1, got);
    for (int i = 0; i < 12; i++) begin
      check("ones_data", r_data[i], 9);
      check("ones_addr", r_addr[i], i);
      check("ones_last", r_last[i], (i == 11));
    end
    repeat (4) @(negedge clk);
    check("ones_done_count", done_cnt - d0, 1);
    check("ones_busy_end", busy, 0);

    // Centre tap picks the patch-centre pixel; base offset moves reads only
    all_taps(0);
    write_tap(4, 1);
    for (int a = 0; a < 256; a++)
      fm_mem[a] = (a < 100) ? DATA_W'(a) : ((a < 150) ? DATA_W'(a + 100) : '0);
    start_strip(0);
    collect(12, -1, got);
    for (int i = 0; i < 12; i++) begin
      check("centre_data", r_data[i], ((i / 4) + 1) * 6 + (i % 4) + 1);
      check("centre_addr", r_addr[i], i);
    end
    repeat (3) @(negedge clk);
    start_strip(100);
    collect(12, -1, got);
    for (int i = 0; i < 12; i++) begin
      check("base100_data", r_data[i], 200 + ((i / 4) + 1) * 6 + (i % 4) + 1);
      check("base100_addr", r_addr[i], i);
    end
    repeat (3) @(negedge clk);

    // Most-negative extremes with a consumer stall on result 3 and a blocked kernel write
    all_taps(-256);
    for (int a = 0; a < 512; a++) fm_mem[a] = -9'sd256;
    d0 = done_cnt;
    start_strip(0);
    write_tap(0, 1);
    collect(12, 3, got);
    for (int i = 0; i < 12; i++) check("neg_data", r_data[i], 589824);
    check("neg_last", r_last[11], 1);
    repeat (4) @(negedge clk);
    check("neg_done_count", done_cnt - d0, 1);

    // Stride 2 on the second engine
    all_taps(1);
    for (int a = 0; a < 512; a++) fm_mem[a] = (a < 100) ? DATA_W'(a) : '0;
    rd2_q.delete();
    start2 = 1'b1; @(negedge clk); start2 = 1'b0;
    got = 0; cyc = 0;
    while (got < 4 && cyc < 400) begin
      if (out_valid2) begin
        r_data[got] = out_data2; r_addr[got] = int'(out_addr2); r_last[got] = out_last2;
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    check("s2_count", got, 4);
    check("s2_data0", r_data[0], 63);
    check("s2_data1", r_data[1], 81);
    check("s2_data2", r_data[2], 171);
    check("s2_data3", r_data[3], 189);
    for (int i = 0; i < 4; i++) begin
      check("s2_addr", r_addr[i], i);
      check("s2_last", r_last[i], (i == 3));
    end
    repeat (3) @(negedge clk);
    check("s2_reads", rd2_q.size(), 36);
    check("s2_done_count", done2_cnt, 1);
    if (rd2_q.size() >= 36) begin
      for (int ky = 0; ky < 3; ky++)
        for (int kx = 0; kx < 3; kx++)
          check("s2_patch11_addr", rd2_q[27 + ky * 3 + kx], 14 + ky * 6 + kx);
    end

    // Reset in the middle of fetching patch 5, then a clean rerun
    for (int a = 0; a < 512; a++) fm_mem[a] = 9'sd1;
    start_strip(0);
    collect(5, -1, got);
    cyc = 0;
    while (!fm_rd_en && cyc < 50) begin @(negedge clk); cyc++; end
    check("patch5_fetch_seen", fm_rd_en, 1);
    repeat (3) @(negedge clk);
    d0 = done_cnt;
    #2 reset = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_fm_rd_en", fm_rd_en, 0);
    check("midrst_fm_addr", fm_addr, 0);
    check("midrst_busy", busy, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_addr", out_addr, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("midrst_no_done", done_cnt - d0, 0);
    all_taps(1);
    start_strip(0);
    collect(12, -1, got);
    for (int i = 0; i < 12; i++) begin
      check("rerun_data", r_data[i], 9);
      check("rerun_addr", r_addr[i], i);
    end
    check("rerun_last", r_last[11], 1);
    repeat (4) @(negedge clk);
    check("rerun_done_count", done_cnt - d0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
